// File: rtl/gpio_pin_change_rx_if.sv
// ============================================================================
// Module   : gpio_pin_change_rx_if
// Brief    : Peripheral register bus between the core and the pin-change block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gpio_pin_change_rx_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       bus_addr;
    logic [WIDTH-1:0] bus_wdata;
    logic             bus_we;
    logic             bus_re;
    logic [WIDTH-1:0] bus_rdata;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_re,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_re,
        output bus_rdata
    );
endinterface

`default_nettype wire

// File: rtl/gpio_pin_change_rx.sv
// ============================================================================
// Module   : gpio_pin_change_rx
// Brief    : GPIO input side: synchronise, glitch-filter, edge-detect pins and
//            raise a maskable pin-change interrupt with sticky W1C flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_pin_change_rx #(
    parameter int WIDTH         = 8,
    parameter int FILTER_CYCLES = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    gpio_pin_change_rx_if.slave   bus,
    input  wire logic [WIDTH-1:0] pin_in,
    output logic      [WIDTH-1:0] pin_value,
    output logic                  irq
);

    localparam int c_cnt_w = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_CYCLES - 1);

    localparam logic [1:0] c_addr_pin   = 2'd0;
    localparam logic [1:0] c_addr_mask  = 2'd1;
    localparam logic [1:0] c_addr_flag  = 2'd2;
    localparam logic [1:0] c_addr_ctrl  = 2'd3;

    localparam logic [1:0] c_edge_rise  = 2'b01;
    localparam logic [1:0] c_edge_fall  = 2'b10;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] r_filt_q;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_flag;
    logic [2:0]       r_ctrl;
    logic [WIDTH-1:0] r_rdata;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_ctrl_ext;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_wr_mask;
    logic             w_wr_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pin_in;
            r_sync2 <= r_sync1;
        end
    end

    // A level must disagree with the filtered value for FILTER_CYCLES
    // consecutive cycles before it is accepted.
    for (genvar i = 0; i < WIDTH; i++) begin : g_filt
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_bit;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_bit <= 1'b0;
            end else if (r_sync2[i] != r_bit) begin
                if (r_cnt == c_cnt_last) begin
                    r_bit <= r_sync2[i];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end

        assign w_filt[i] = r_bit;
    end

    assign w_rise = w_filt & ~r_filt_q;
    assign w_fall = ~w_filt & r_filt_q;

    always_comb begin
        w_event = w_rise | w_fall;
        case (r_ctrl[2:1])
            c_edge_rise: w_event = w_rise;
            c_edge_fall: w_event = w_fall;
            default:     w_event = w_rise | w_fall;
        endcase
    end

    assign w_wr_mask = bus.bus_we && (bus.bus_addr == c_addr_mask);
    assign w_wr_ctrl = bus.bus_we && (bus.bus_addr == c_addr_ctrl);
    assign w_clr     = (bus.bus_we && (bus.bus_addr == c_addr_flag)) ? bus.bus_wdata : '0;

    always_comb begin
        w_ctrl_ext      = '0;
        w_ctrl_ext[2:0] = r_ctrl;
    end

    always_comb begin
        w_rd_data = '0;
        case (bus.bus_addr)
            c_addr_pin:  w_rd_data = w_filt;
            c_addr_mask: w_rd_data = r_mask;
            c_addr_flag: w_rd_data = r_flag;
            c_addr_ctrl: w_rd_data = w_ctrl_ext;
            default:     w_rd_data = '0;
        endcase
    end

    // New events are ORed in after the clear so a coincident set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_q <= '0;
            r_mask   <= '0;
            r_flag   <= '0;
            r_ctrl   <= '0;
            r_rdata  <= '0;
        end else begin
            r_filt_q <= w_filt;
            r_flag   <= (r_flag & ~w_clr) | (r_mask & w_event);
            if (w_wr_mask) begin
                r_mask <= bus.bus_wdata;
            end
            if (w_wr_ctrl) begin
                r_ctrl <= bus.bus_wdata[2:0];
            end
            if (bus.bus_re) begin
                r_rdata <= w_rd_data;
            end
        end
    end

    assign bus.bus_rdata = r_rdata;
    assign pin_value     = w_filt;
    assign irq           = r_ctrl[0] & (|r_flag);

endmodule

`default_nettype wire

// File: tb/tb_gpio_pin_change_rx.sv
// ============================================================================
// Module   : tb_gpio_pin_change_rx
// Brief    : Directed self-checking bench for gpio_pin_change_rx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_pin_change_rx;

    logic       clk;
    logic       rst_n;
    logic [7:0] pin_in;
    logic [7:0] pin_value;
    logic       irq;
    logic [7:0] rd;
    int         checks;
    int         errors;

    gpio_pin_change_rx_if #(.WIDTH(8)) bus_if ();

    gpio_pin_change_rx #(
        .WIDTH         (8),
        .FILTER_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .pin_in    (pin_in),
        .pin_value (pin_value),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, landing 1 ns after the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = data;
        bus_if.bus_we    = 1'b1;
        cyc(1);
        bus_if.bus_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
        bus_if.bus_addr = addr;
        bus_if.bus_re   = 1'b1;
        cyc(1);
        bus_if.bus_re   = 1'b0;
        data = bus_if.bus_rdata;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus_if.bus_addr  = 2'd0;
        bus_if.bus_wdata = 8'h00;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_re    = 1'b0;
        pin_in = 8'hFF;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_pin_value", pin_value, 8'h00);
        check("reset_irq", {7'd0, irq}, 8'h00);
        check("reset_rdata", bus_if.bus_rdata, 8'h00);

        // Startup with all pins high: filtered value climbs, no flag.
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        check("startup_pin_value", pin_value, 8'hFF);
        bus_read(2'd2, rd);
        check("startup_flag", rd, 8'h00);
        check("startup_irq", {7'd0, irq}, 8'h00);

        // Rising edge on bit 0 with latency check.
        pin_in = 8'hFE;
        cyc(10);
        check("pin0_low", pin_value, 8'hFE);
        bus_write(2'd1, 8'h01);
        bus_write(2'd3, 8'h01);
        pin_in = 8'hFF;
        cyc(5);
        check("latency_e0p4", pin_value, 8'hFE);
        cyc(1);
        check("latency_e0p5", pin_value, 8'hFF);
        check("irq_before_flag", {7'd0, irq}, 8'h00);
        cyc(1);
        check("irq_after_flag", {7'd0, irq}, 8'h01);
        bus_read(2'd2, rd);
        check("flag_bit0", rd, 8'h01);
        bus_write(2'd2, 8'h01);
        check("w1c_irq", {7'd0, irq}, 8'h00);
        bus_read(2'd2, rd);
        check("w1c_flag", rd, 8'h00);

        // Glitch of 3 cycles on bit 3 is rejected, 4 cycles is accepted.
        pin_in = 8'hF7;
        cyc(10);
        bus_write(2'd1, 8'hFF);
        pin_in = 8'hFF;
        cyc(3);
        pin_in = 8'hF7;
        cyc(10);
        check("glitch3_pin_value", pin_value, 8'hF7);
        bus_read(2'd2, rd);
        check("glitch3_flag", rd, 8'h00);
        check("glitch3_irq", {7'd0, irq}, 8'h00);
        pin_in = 8'hFF;
        cyc(4);
        pin_in = 8'hF7;
        cyc(12);
        bus_read(2'd2, rd);
        check("pulse4_flag", rd, 8'h08);
        bus_write(2'd2, 8'h08);

        // Rising-only selection.
        bus_write(2'd3, 8'h03);
        pin_in = 8'hF3;
        cyc(10);
        bus_read(2'd2, rd);
        check("rise_only_fall", rd, 8'h00);
        pin_in = 8'hF7;
        cyc(10);
        bus_read(2'd2, rd);
        check("rise_only_rise", rd, 8'h04);
        check("rise_only_irq", {7'd0, irq}, 8'h01);

        // Event and W1C on the same edge: set wins.
        pin_in = 8'hF3;
        cyc(10);
        pin_in = 8'hF7;
        cyc(6);
        check("collide_pin", pin_value, 8'hF7);
        bus_write(2'd2, 8'h04);
        check("collide_irq", {7'd0, irq}, 8'h01);
        bus_read(2'd2, rd);
        check("collide_flag", rd, 8'h04);

        // Mask cleared keeps flags; PIN writes ignored; read returns pre-write value.
        bus_write(2'd1, 8'h00);
        bus_read(2'd2, rd);
        check("mask0_keeps_flag", rd, 8'h04);
        bus_read(2'd3, rd);
        check("ctrl_readback", rd, 8'h03);
        bus_write(2'd0, 8'h00);
        bus_read(2'd0, rd);
        check("pin_write_ignored", rd, 8'hF7);
        bus_if.bus_addr  = 2'd1;
        bus_if.bus_wdata = 8'h5A;
        bus_if.bus_we    = 1'b1;
        bus_if.bus_re    = 1'b1;
        cyc(1);
        bus_if.bus_we    = 1'b0;
        bus_if.bus_re    = 1'b0;
        check("rw_old_value", bus_if.bus_rdata, 8'h00);
        bus_read(2'd1, rd);
        check("rw_new_value", rd, 8'h5A);

        // Build PCFLAG = A5 then reset asynchronously mid-cycle.
        bus_write(2'd1, 8'hFF);
        bus_write(2'd3, 8'h01);
        bus_write(2'd2, 8'hFF);
        pin_in = 8'hF7 ^ 8'hA5;
        cyc(12);
        bus_read(2'd2, rd);
        check("flag_a5", rd, 8'hA5);
        check("flag_a5_irq", {7'd0, irq}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check("async_irq", {7'd0, irq}, 8'h00);
        check("async_rdata", bus_if.bus_rdata, 8'h00);
        check("async_pin_value", pin_value, 8'h00);
        cyc(2);
        rst_n = 1'b1;
        bus_read(2'd1, rd);
        check("post_reset_mask", rd, 8'h00);
        bus_read(2'd3, rd);
        check("post_reset_ctrl", rd, 8'h00);
        bus_read(2'd2, rd);
        check("post_reset_flag", rd, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
